switch_conditioner: RTL
=======================

Name: switch_conditioner

Overview:
- Upstream input stage for the LED game status/scoring block: takes the 10 raw board slide switches and produces the clean `switch` vector that block consumes.
- Per switch: synchronises, debounces on a shared slow sample tick, and detects press (rising) edges.
- A capture FSM latches exactly one valid one-hot press per round, holds it until the consumer clears it, and flags multi-switch presses as errors.

Parameters:
- WIDTH, 10, number of switches (press_index width is 4 for WIDTH<=16).
- TICK_DIV, 50000, clock cycles per debounce sample tick (minimum 2).
- STABLE_SAMPLES, 4, consecutive differing samples required to accept a new level (minimum 2).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- switch_raw  input  WIDTH  asynchronous raw switch levels.
- clear  input  1  consumer acknowledge; releases the latched press.
- switch_out  output  WIDTH  debounced switch levels.
- press_valid  output  1  one-cycle pulse when a single press is latched.
- press_vec  output  WIDTH  latched one-hot press; zero when nothing is latched.
- press_index  output  4  binary index of the latched press bit; 0 when none.
- multi_err  output  1  high while a multi-switch press is being rejected.

Behaviour:
- Reset: one clock, single reset port named `reset`, synchronous and active-high. On reset all of the following go to 0, regardless of FSM state or counter values: outputs, synchroniser flops, prescaler, per-bit counters, previous-level register. FSM enters IDLE.
- Synchroniser: two flops per bit; sync[i] lags switch_raw[i] by 2 clocks.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle in which count==TICK_DIV-1.
- Debounce, per bit, only on tick:
  - If sync[i]==switch_out[i], cnt[i] <= 0.
  - Else if cnt[i]==STABLE_SAMPLES-1, toggle switch_out[i] and set cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A glitch shorter than STABLE_SAMPLES ticks never reaches switch_out.
  - Release (1->0) uses the same rule.
- Edge detection: prev <= switch_out every cycle; rise = switch_out & ~prev.
- FSM states IDLE, HELD, WAIT_RELEASE:
  - IDLE, rise==0: stay.
  - IDLE, rise exactly one-hot: press_vec <= rise, press_index <= bit position, press_valid=1 for one cycle, go to HELD.
  - IDLE, rise has more than one bit: multi_err <= 1, go to WAIT_RELEASE; press_vec stays 0, no press_valid.
  - HELD: further rises are ignored and press_vec/press_index hold. On clear: press_vec <= 0, press_index <= 0, go to WAIT_RELEASE.
  - WAIT_RELEASE: when switch_out==0, multi_err <= 0 and go to IDLE. Rises in this state are ignored.
- clear is ignored outside HELD.
- Simultaneous clear and rise in HELD: the clear is taken and the rise is dropped; the switch must be released and pressed again.
- Latency:
  - press_valid is asserted the cycle after switch_out rises.
  - switch_out changes on the STABLE_SAMPLES-th tick after sync first differs.
  - With TICK_DIV=4 and STABLE_SAMPLES=3, that is 11 to 14 cycles after switch_raw changes.
- Counter width: clog2(STABLE_SAMPLES) bits per switch. Prescaler width: clog2(TICK_DIV) bits.

Decomposition:
- Shared package `led_game_pkg`:
  - SWITCH_COUNT=10.
  - FSM state enum for this block (2-bit).
  - The one-hot-to-index function, reused by the status block for LED checks.
- One natural sub-module: `debounce_bit` (synchroniser plus counter plus level for one switch), instantiated WIDTH times with a shared tick.
- Prescaler and capture FSM stay in the top module.

Test Plan:
Use TICK_DIV=4 and STABLE_SAMPLES=3 for all scenarios.
1. Reset mid-operation: hold switch_raw=10'h3FF, assert reset for 1 cycle during debounce -> all outputs 0 the next cycle; switch_out rises again only after a full 3-tick window.
2. Clean single press: switch_raw=10'b1000000000 -> switch_out[9] rises within 11-14 cycles; press_valid pulses once; press_vec=10'b1000000000; press_index=9.
3. Glitch rejection: switch_raw[3] high for 6 cycles then low -> switch_out, press_valid and press_vec stay 0 throughout.
4. Multi press: switch_raw 0 -> 10'b0000000101 in one cycle -> multi_err=1, no press_valid, press_vec=0. After release and debounce, multi_err=0 and FSM is back in IDLE.
5. Hold, second press, clear:
   - Latch bit 2, then press bit 5 while HELD -> press_vec stays 10'b0000000100.
   - Pulse clear -> press_vec=0, press_index=0.
   - Release all switches, then press bit 5 -> new press_valid with press_index=5.
6. clear coincident with a new rise in HELD -> no press_valid. Subsequent press after full release is accepted normally.

Source files
------------

// File: rtl/led_game_pkg.sv
// Shared types and helpers for the LED game: switch count, capture FSM states
// and the one-hot decoding used here and by the status/scoring block.
package led_game_pkg;

   localparam int SWITCH_COUNT = 10;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_HELD         = 2'd1,
      ST_WAIT_RELEASE = 2'd2
   } capture_state_t;

   // Binary position of the set bit; a zero vector decodes to 0.
   function automatic logic [3:0] onehotToIndex(input logic [15:0] i_vec);
      logic [3:0] idx;
      idx = '0;
      for (int b = 0; b < 16; b++) begin
         if (i_vec[b]) idx = idx | 4'(b);
      end
      return idx;
   endfunction

   function automatic logic isOneHot(input logic [15:0] i_vec);
      return (i_vec != '0) && ((i_vec & (i_vec - 16'd1)) == '0);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch: two-flop synchroniser feeding a tick-sampled counter that only
// accepts a new level after STABLE_SAMPLES consecutive differing samples.
module debounce_bit #(
   parameter int STABLE_SAMPLES = 4,
   parameter int CNT_W          = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic             r_syncMeta;
   logic             r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   // Any sample matching the current level restarts the stability window.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_syncMeta <= 1'b0;
         r_sync     <= 1'b0;
         r_level    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_syncMeta <= i_raw;
         r_sync     <= r_syncMeta;
         if (i_tick) begin
            if (r_sync == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/switch_conditioner.sv
// Raw slide switches in, clean debounced levels plus a single latched one-hot
// press (held until cleared) out; simultaneous multi-switch presses are rejected.
module switch_conditioner
   import led_game_pkg::*;
#(
   parameter int WIDTH          = SWITCH_COUNT,
   parameter int TICK_DIV       = 50000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switch_raw,
   input  logic             clear,
   output logic [WIDTH-1:0] switch_out,
   output logic             press_valid,
   output logic [WIDTH-1:0] press_vec,
   output logic [3:0]       press_index,
   output logic             multi_err
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int CNT_W = $clog2(STABLE_SAMPLES);

   logic [PRE_W-1:0] r_prescale;
   logic             w_tick;
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_rise;
   logic [15:0]      w_riseExt;
   capture_state_t   r_state;

   assign w_tick = (r_prescale == PRE_W'(TICK_DIV - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_prescale <= '0;
      end else if (w_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + PRE_W'(1);
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES),
         .CNT_W         (CNT_W)
      ) u_bit (
         .clock  (clock),
         .reset  (reset),
         .i_raw  (switch_raw[g]),
         .i_tick (w_tick),
         .o_level(w_level[g])
      );
   end

   assign switch_out = w_level;
   assign w_rise     = switch_out & ~r_prev;
   assign w_riseExt  = 16'(w_rise);

   // Clear has priority in HELD, so a rise arriving with it is lost and the
   // player has to release and press again.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prev      <= '0;
         r_state     <= ST_IDLE;
         press_valid <= 1'b0;
         press_vec   <= '0;
         press_index <= '0;
         multi_err   <= 1'b0;
      end else begin
         r_prev      <= switch_out;
         press_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise != '0) begin
                  if (isOneHot(w_riseExt)) begin
                     press_vec   <= w_rise;
                     press_index <= onehotToIndex(w_riseExt);
                     press_valid <= 1'b1;
                     r_state     <= ST_HELD;
                  end else begin
                     multi_err <= 1'b1;
                     r_state   <= ST_WAIT_RELEASE;
                  end
               end
            end
            ST_HELD: begin
               if (clear) begin
                  press_vec   <= '0;
                  press_index <= '0;
                  r_state     <= ST_WAIT_RELEASE;
               end
            end
            ST_WAIT_RELEASE: begin
               if (switch_out == '0) begin
                  multi_err <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
